// File: rtl/jump_control_unit.sv
// ---------------------------------------------------------------------------
// jump_control_unit
//
// Jump/branch control for the 16-bit MIPS-style pipeline. It decodes the
// opcode, evaluates jump conditions against the execute-stage flags and
// services a single-level hardware interrupt. It then drives the PC-source
// mux select and the target address.
//
// Build option:
//   JC_FLAG_RESTORE_EN  When defined, flags are saved at interrupt entry.
//                       The first conditional after RET uses those saved
//                       flags. When undefined, conditionals always use
//                       the live flag_ex.
//
// Ports:
//   clk              system clock, rising-edge
//   reset            synchronous, active-high reset
//   jmp_address_pm   jump target from program memory
//   current_address  PC of the instruction in flight (return address)
//   op               6-bit opcode
//   flag_ex          execute-stage flags, bit0 = Z, bit1 = V
//   interrupt        level interrupt request
//   jmp_loc          next-PC value used when pc_mux_sel = 1
//   pc_mux_sel       1 = load PC from jmp_loc, 0 = sequential PC
//
// state      | meaning
// -----------+--------------------------------------------------
// ISR_IDLE   | normal execution; an interrupt request is accepted
// ISR_ACTIVE | in service routine; requests ignored, RET returns
// ---------------------------------------------------------------------------
module jump_control_unit #(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] INT_VECTOR = 16'hF000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] jmp_address_pm,
    input  logic [ADDR_W-1:0] current_address,
    input  logic [5:0]        op,
    input  logic [1:0]        flag_ex,
    input  logic              interrupt,
    output logic [ADDR_W-1:0] jmp_loc,
    output logic              pc_mux_sel
);

    localparam logic [5:0] OP_JMP = 6'h18;
    localparam logic [5:0] OP_JZ  = 6'h1C;
    localparam logic [5:0] OP_JNZ = 6'h1D;
    localparam logic [5:0] OP_JV  = 6'h1E;
    localparam logic [5:0] OP_JNV = 6'h1F;
    localparam logic [5:0] OP_RET = 6'h10;

    typedef enum logic {
        ISR_IDLE   = 1'b0,
        ISR_ACTIVE = 1'b1
    } isr_state_t;

    isr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
    logic [1:0]        eff_flags;
    logic              accept_int;
    logic              do_ret;
    logic              jump_taken;

`ifdef JC_FLAG_RESTORE_EN
    logic [1:0] saved_flags_q, saved_flags_d;
    logic       restore_pending_q, restore_pending_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ISR_IDLE;
            ret_addr_q <= '0;
`ifdef JC_FLAG_RESTORE_EN
            saved_flags_q     <= 2'b00;
            restore_pending_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ret_addr_q <= ret_addr_d;
`ifdef JC_FLAG_RESTORE_EN
            saved_flags_q     <= saved_flags_d;
            restore_pending_q <= restore_pending_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        ret_addr_d = ret_addr_q;
        pc_mux_sel = 1'b0;
        jmp_loc    = jmp_address_pm;
        jump_taken = 1'b0;

`ifdef JC_FLAG_RESTORE_EN
        saved_flags_d     = saved_flags_q;
        // The restore window lasts exactly one cycle.
        restore_pending_d = 1'b0;
        eff_flags         = restore_pending_q ? saved_flags_q : flag_ex;
`else
        eff_flags         = flag_ex;
`endif

        // Accept and RET are mutually exclusive because they need
        // opposite ISR states.
        accept_int = interrupt && (state_q == ISR_IDLE);
        do_ret     = (op == OP_RET) && (state_q == ISR_ACTIVE);

        case (op)
            OP_JMP:  jump_taken = 1'b1;
            OP_JZ:   jump_taken = eff_flags[0];
            OP_JNZ:  jump_taken = !eff_flags[0];
            OP_JV:   jump_taken = eff_flags[1];
            OP_JNV:  jump_taken = !eff_flags[1];
            default: jump_taken = 1'b0;
        endcase

        if (reset) begin
            pc_mux_sel = 1'b0;
            jmp_loc    = '0;
        end else if (accept_int) begin
            pc_mux_sel = 1'b1;
            jmp_loc    = INT_VECTOR;
            state_d    = ISR_ACTIVE;
            ret_addr_d = current_address;
`ifdef JC_FLAG_RESTORE_EN
            saved_flags_d = flag_ex;
`endif
        end else if (do_ret) begin
            pc_mux_sel = 1'b1;
            jmp_loc    = ret_addr_q;
            state_d    = ISR_IDLE;
`ifdef JC_FLAG_RESTORE_EN
            restore_pending_d = 1'b1;
`endif
        end else if (jump_taken) begin
            pc_mux_sel = 1'b1;
            jmp_loc    = jmp_address_pm;
        end
    end

endmodule

// File: tb/tb_jump_control_unit.sv
// ---------------------------------------------------------------------------
// tb_jump_control_unit
//
// Directed testbench for jump_control_unit. Inputs are driven 1 ns after
// the rising edge. Outputs are sampled 2 ns later, well before the next
// edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_jump_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] jmp_address_pm;
    logic [15:0] current_address;
    logic [5:0]  op;
    logic [1:0]  flag_ex;
    logic        interrupt;
    logic [15:0] jmp_loc;
    logic        pc_mux_sel;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    jump_control_unit dut (
        .clk             (clk),
        .reset           (reset),
        .jmp_address_pm  (jmp_address_pm),
        .current_address (current_address),
        .op              (op),
        .flag_ex         (flag_ex),
        .interrupt       (interrupt),
        .jmp_loc         (jmp_loc),
        .pc_mux_sel      (pc_mux_sel)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle's inputs, then wait until the sample point.
    task automatic drive(input logic rst, input logic [5:0] o, input logic [15:0] addr,
                         input logic [15:0] cur, input logic [1:0] flg, input logic irq);
        reset           = rst;
        op              = o;
        jmp_address_pm  = addr;
        current_address = cur;
        flag_ex         = flg;
        interrupt       = irq;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] cond_op  [8] = '{6'h1C, 6'h1D, 6'h1E, 6'h1F, 6'h1C, 6'h1D, 6'h1E, 6'h1F};
    logic [1:0] cond_flg [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11};
    logic       cond_exp [8] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0};

    logic exp_restore;

    initial begin
        #1;
        // Reset held two cycles with a jump and an interrupt pending.
        drive(1'b1, 6'h18, 16'h0008, 16'h0001, 2'b00, 1'b1);
        check("rst1_sel", pc_mux_sel, 1'b0);
        check("rst1_loc", jmp_loc, 16'h0000);
        tick();
        drive(1'b1, 6'h18, 16'h0008, 16'h0001, 2'b00, 1'b1);
        check("rst2_sel", pc_mux_sel, 1'b0);
        check("rst2_loc", jmp_loc, 16'h0000);
        tick();
        drive(1'b0, 6'h00, 16'h1234, 16'h0000, 2'b00, 1'b0);
        check("idle_sel", pc_mux_sel, 1'b0);
        check("idle_loc_pass", jmp_loc, 16'h1234);
        tick();

        // Interrupt entry. The opcode in the same cycle is ignored.
        drive(1'b0, 6'h18, 16'h0008, 16'h0001, 2'b00, 1'b1);
        check("int_sel", pc_mux_sel, 1'b1);
        check("int_loc", jmp_loc, 16'hF000);
        tick();
        drive(1'b0, 6'h00, 16'h0008, 16'h0002, 2'b00, 1'b1);
        check("int_in_isr_sel", pc_mux_sel, 1'b0);
        tick();

        // Jump inside the ISR with the request still high.
        drive(1'b0, 6'h18, 16'h0008, 16'h0003, 2'b00, 1'b1);
        check("jmp_sel", pc_mux_sel, 1'b1);
        check("jmp_loc", jmp_loc, 16'h0008);
        tick();

        // RET, then a second RET, which is a no-op.
        drive(1'b0, 6'h10, 16'h0008, 16'h0004, 2'b00, 1'b0);
        check("ret_sel", pc_mux_sel, 1'b1);
        check("ret_loc", jmp_loc, 16'h0001);
        tick();
        drive(1'b0, 6'h10, 16'h0008, 16'h0002, 2'b00, 1'b0);
        check("ret2_sel", pc_mux_sel, 1'b0);
        tick();

        // Conditional jumps across both flag polarities.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, cond_op[i], 16'h0008, 16'h0010, cond_flg[i], 1'b0);
            check($sformatf("cond%0d_sel", i), pc_mux_sel, cond_exp[i]);
            if (cond_exp[i])
                check($sformatf("cond%0d_loc", i), jmp_loc, 16'h0008);
            tick();
        end
        drive(1'b0, 6'h19, 16'h0008, 16'h0010, 2'b11, 1'b0);
        check("nonjump_sel", pc_mux_sel, 1'b0);
        tick();

        // A held request is accepted once. A request during RET is
        // accepted on the next cycle.
        drive(1'b0, 6'h00, 16'h0000, 16'h0040, 2'b00, 1'b1);
        check("held1_sel", pc_mux_sel, 1'b1);
        check("held1_loc", jmp_loc, 16'hF000);
        tick();
        drive(1'b0, 6'h00, 16'h0000, 16'h0041, 2'b00, 1'b1);
        check("held2_sel", pc_mux_sel, 1'b0);
        tick();
        drive(1'b0, 6'h10, 16'h0000, 16'h0042, 2'b00, 1'b1);
        check("ret_irq_sel", pc_mux_sel, 1'b1);
        check("ret_irq_loc", jmp_loc, 16'h0040);
        tick();
        drive(1'b0, 6'h00, 16'h0000, 16'h0050, 2'b00, 1'b1);
        check("reaccept_sel", pc_mux_sel, 1'b1);
        check("reaccept_loc", jmp_loc, 16'hF000);
        tick();

        // Reset in the middle of an ISR. A later RET does nothing.
        drive(1'b1, 6'h10, 16'h0000, 16'h0051, 2'b00, 1'b0);
        check("midrst_sel", pc_mux_sel, 1'b0);
        check("midrst_loc", jmp_loc, 16'h0000);
        tick();
        drive(1'b0, 6'h10, 16'h0077, 16'h0052, 2'b00, 1'b0);
        check("ret_after_rst_sel", pc_mux_sel, 1'b0);
        check("ret_after_rst_loc", jmp_loc, 16'h0077);
        tick();

        // Flag restore: Z is saved at entry and is clear in the ISR.
`ifdef JC_FLAG_RESTORE_EN
        exp_restore = 1'b1;
`else
        exp_restore = 1'b0;
`endif
        drive(1'b0, 6'h00, 16'h0000, 16'h0100, 2'b01, 1'b1);
        check("fr_int_sel", pc_mux_sel, 1'b1);
        tick();
        drive(1'b0, 6'h10, 16'h0008, 16'h0200, 2'b00, 1'b0);
        check("fr_ret_loc", jmp_loc, 16'h0100);
        tick();
        drive(1'b0, 6'h1C, 16'h0008, 16'h0101, 2'b00, 1'b0);
        check("fr_jz_sel", pc_mux_sel, exp_restore);
        tick();
        drive(1'b0, 6'h1C, 16'h0008, 16'h0102, 2'b00, 1'b0);
        check("fr_jz_live_sel", pc_mux_sel, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/jump_control_unit.md
Name: jump_control_unit

Overview:
- Jump/branch control unit of the 16-bit MIPS-style pipeline.
- Decodes the 6-bit opcode from the fetch/decode stage, evaluates jump conditions against the execute-stage flags, and services a single-level hardware interrupt.
- Drives the PC-source mux select and the target address.
- Sits beside the program counter; `jmp_address_pm` comes from program memory (the instruction's address field) and `current_address` is the PC of the instruction in flight.

Parameters:
- `INT_VECTOR`, 16'hF000, interrupt service routine entry address.
- `ADDR_W`, 16, address width of `jmp_address_pm`, `current_address`, `jmp_loc` and the return-address register.

Ports:
- `clk`  input  1  system clock, all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `jmp_address_pm`  input  16  jump target from program memory.
- `current_address`  input  16  PC of the current instruction; saved as return address on interrupt.
- `op`  input  6  instruction opcode.
- `flag_ex`  input  2  execute-stage flags: bit0 = zero (Z), bit1 = overflow (V).
- `interrupt`  input  1  interrupt request, level, sampled each cycle.
- `jmp_loc`  output  16  next-PC value when `pc_mux_sel`=1.
- `pc_mux_sel`  output  1  1 = load PC from `jmp_loc`; 0 = sequential PC.

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous and active-high.
- State registers:
  - `ret_addr[15:0]`
  - `saved_flags[1:0]`
  - `in_isr` (interrupt-in-service flag)
  - `restore_pending` (1-cycle flag)
  - All clear to 0 on the clock edge where `reset`=1.
- Outputs are combinational from inputs and state.
- While `reset`=1: `pc_mux_sel`=0 and `jmp_loc`=16'h0000, regardless of other inputs.
- Opcode decode (all others are non-jump):
  - 6'h18 JMP: unconditional.
  - 6'h1C JZ: taken if Z=1.
  - 6'h1D JNZ: taken if Z=0.
  - 6'h1E JV: taken if V=1.
  - 6'h1F JNV: taken if V=0.
  - 6'h10 RET: return from interrupt.
- Condition flags: `eff_flags` = `saved_flags` when `restore_pending`=1, else `flag_ex`.
- Priority, highest first:
  1. Interrupt accept: `interrupt`=1 and `in_isr`=0.
     - `pc_mux_sel`=1, `jmp_loc`=`INT_VECTOR`.
     - At the clock edge: `ret_addr`<=`current_address`, `saved_flags`<=`flag_ex`, `in_isr`<=1.
     - Any opcode in that cycle is ignored.
  2. RET with `in_isr`=1.
     - `pc_mux_sel`=1, `jmp_loc`=`ret_addr`.
     - At the edge: `in_isr`<=0, `restore_pending`<=1.
  3. Taken JMP/JZ/JNZ/JV/JNV: `pc_mux_sel`=1, `jmp_loc`=`jmp_address_pm`.
  4. Otherwise: `pc_mux_sel`=0, `jmp_loc`=`jmp_address_pm` (pass-through, ignored by PC).
- `restore_pending` is cleared on every edge where it is not being set (exactly one cycle).
- Boundary cases:
  - `interrupt`=1 while `in_isr`=1: ignored, not queued. Jumps execute normally.
  - RET while `in_isr`=0: treated as non-jump (`pc_mux_sel`=0), no state change.
  - `interrupt` held high across several cycles: accepted once only, on the first cycle with `in_isr`=0.
  - A request still asserted in the cycle of RET is ignored because `in_isr`=1 then. It is accepted in the following cycle if still high.
  - Reset mid-ISR: all state cleared; a subsequent RET is a no-op.
- No pipeline latency: decisions are visible in the same cycle as their inputs. State-updating decisions commit at the next rising edge.

Optional Feature:
- Macro: `JC_FLAG_RESTORE_EN`.
- Defined:
  - `saved_flags` and `restore_pending` are implemented as above.
  - The first conditional jump after RET evaluates the flags saved at interrupt entry.
- Undefined:
  - `saved_flags` and `restore_pending` are removed.
  - Conditionals always use live `flag_ex`.
  - Interrupt entry and RET address handling are unchanged.

Test Plan:
1. Reset: hold `reset`=1 two cycles with `op`=6'h18, `interrupt`=1 -> `pc_mux_sel`=0, `jmp_loc`=16'h0000. After release with `op`=6'h00, `interrupt`=0 -> `pc_mux_sel`=0.
2. Interrupt entry: `current_address`=16'h0001, `interrupt`=1 for one cycle -> `pc_mux_sel`=1, `jmp_loc`=16'hF000 that cycle. A second `interrupt` pulse while in ISR -> `pc_mux_sel`=0.
3. Unconditional jump: `jmp_address_pm`=16'h0008, `op`=6'h18 -> `pc_mux_sel`=1, `jmp_loc`=16'h0008.
4. RET: after scenario 2, `op`=6'h10 -> `pc_mux_sel`=1, `jmp_loc`=16'h0001. A second RET -> `pc_mux_sel`=0.
5. Conditionals with `flag_ex`=2'b00, `jmp_address_pm`=16'h0008:
   - `op`=6'h1C -> `pc_mux_sel`=0.
   - 6'h1D -> 1.
   - 6'h1E -> 0.
   - 6'h1F -> 1.
   - With `flag_ex`=2'b11 the results invert.
6. Flag restore (`JC_FLAG_RESTORE_EN`):
   - Interrupt taken with `flag_ex`=2'b01; `flag_ex` changed to 2'b00 in ISR.
   - RET, then `op`=6'h1C next cycle -> `pc_mux_sel`=1 (saved Z used).
   - Macro undefined -> `pc_mux_sel`=0.
